seq_mult: RTL and testbench

SEQ_MULT -- requirements
Module: seq_mult

---
 rtl/seq_mult_if.sv | 28 ++
 rtl/seq_mult.sv | 103 ++++++++++
 tb/tb_seq_mult.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_if.sv
// seq_mult_if -- request/result bundle for the sequential multiplier.
//   start : begin a multiply (sampled only while the multiplier is idle)
//   sgn   : 0 = unsigned operands, 1 = two's-complement operands
//   a, b  : multiplicand / multiplier, sampled together with start
//   c     : registered 2*WIDTH product, held until the next result
//   busy  : high from the accepting edge until the cycle after done
//   done  : one-cycle pulse marking a fresh value on c
interface seq_mult_if #(
   parameter int unsigned WIDTH = 8
);
   logic                 start;
   logic                 sgn;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [2*WIDTH-1:0]   c;
   logic                 busy;
   logic                 done;

   modport master (
      output start, sgn, a, b,
      input  c, busy, done
   );

   modport slave (
      input  start, sgn, a, b,
      output c, busy, done
   );
endinterface

// File: rtl/seq_mult.sv
// seq_mult -- shift-add multiplier, one iteration per clock, WIDTH iterations.
//   clk : rising-edge clock for all state
//   cr  : asynchronous active-low reset
//   bus : seq_mult_if slave (start/sgn/a/b in, c/busy/done out)
// Signed operands are reduced to magnitudes up front; the product sign is
// reapplied when c is written, so the datapath itself is purely unsigned.
module seq_mult #(
   parameter int unsigned WIDTH = 8
) (
   input  logic      clk,
   input  logic      cr,
   seq_mult_if.slave bus
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t               state;
   logic [2*WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]     mplier;
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        cnt;
   logic                 neg;

   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic                 neg_in;
   logic [2*WIDTH-1:0]   acc_next;

   // Magnitude of the most negative value wraps back to itself, which read
   // as unsigned is exactly 2^(WIDTH-1).
   always_comb begin
      mag_a  = bus.a;
      mag_b  = bus.b;
      neg_in = 1'b0;
      if (bus.sgn) begin
         if (bus.a[WIDTH-1]) mag_a = WIDTH'(~bus.a + WIDTH'(1));
         if (bus.b[WIDTH-1]) mag_b = WIDTH'(~bus.b + WIDTH'(1));
         neg_in = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      end
   end

   always_comb begin
      acc_next = acc;
      if (mplier[0]) acc_next = acc + mcand;
   end

   always_ff @(posedge clk or negedge cr) begin
      if (!cr) begin
         state    <= IDLE;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
         neg      <= 1'b0;
         bus.c    <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  mcand    <= {{WIDTH{1'b0}}, mag_a};
                  mplier   <= mag_b;
                  neg      <= neg_in;
                  acc      <= '0;
                  cnt      <= CW'(WIDTH);
                  bus.busy <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - CW'(1);
               // Final iteration: publish the sum including this step's add.
               if (cnt == CW'(1)) begin
                  bus.c    <= neg ? (~acc_next + 1'b1) : acc_next;
                  bus.done <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult -- self-checking bench for seq_mult at WIDTH=8 and WIDTH=16.
// Expected products come from a constant table or an integer model, are
// queued when start is driven and compared when done pulses.
module tb_seq_mult;

   logic clk;
   logic cr;

   seq_mult_if #(.WIDTH(8))  if8();
   seq_mult_if #(.WIDTH(16)) if16();

   seq_mult #(.WIDTH(8))  dut8  (.clk(clk), .cr(cr), .bus(if8.slave));
   seq_mult #(.WIDTH(16)) dut16 (.clk(clk), .cr(cr), .bus(if16.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          w16;
      bit          s;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   int unsigned  errors;
   int unsigned  checks;
   logic [63:0]  exp_q[$];
   logic [63:0]  prev_c8;
   logic [63:0]  prev_c16;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] get_c(input bit w16);
      return w16 ? {32'h0, if16.c} : {48'h0, if8.c};
   endfunction

   function automatic logic get_busy(input bit w16);
      return w16 ? if16.busy : if8.busy;
   endfunction

   function automatic logic get_done(input bit w16);
      return w16 ? if16.done : if8.done;
   endfunction

   function automatic logic [63:0] model(input bit w16, input bit s, input logic [31:0] a, input logic [31:0] b);
      longint      pa;
      longint      pb;
      logic [63:0] r;
      if (w16) begin
         pa = s ? longint'($signed(a[15:0])) : longint'(a[15:0]);
         pb = s ? longint'($signed(b[15:0])) : longint'(b[15:0]);
      end else begin
         pa = s ? longint'($signed(a[7:0])) : longint'(a[7:0]);
         pb = s ? longint'($signed(b[7:0])) : longint'(b[7:0]);
      end
      r = pa * pb;
      return w16 ? {32'h0, r[31:0]} : {48'h0, r[15:0]};
   endfunction

   task automatic drive(input bit w16, input bit st, input bit s, input logic [31:0] a, input logic [31:0] b);
      if (w16) begin
         if16.start = st; if16.sgn = s; if16.a = a[15:0]; if16.b = b[15:0];
      end else begin
         if8.start = st; if8.sgn = s; if8.a = a[7:0]; if8.b = b[7:0];
      end
   endtask

   // One full transaction: start, latency, result, busy window, return to idle.
   task automatic run_op(input bit w16, input bit s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string tag);
      int unsigned lat;
      int unsigned busy_n;
      int unsigned done_k;
      bit          seen;
      logic [63:0] held;
      lat    = w16 ? 16 : 8;
      held   = w16 ? prev_c16 : prev_c8;
      drive(w16, 1'b1, s, a, b);
      @(posedge clk); #1;
      exp_q.push_back(exp);
      // Scramble inputs after acceptance; the result must not depend on them.
      drive(w16, 1'b0, ~s, $urandom, $urandom);
      busy_n = get_busy(w16) ? 1 : 0;
      seen   = 1'b0;
      done_k = 0;
      for (int unsigned k = 1; k <= lat + 4 && !seen; k++) begin
         @(posedge clk); #1;
         if (get_busy(w16)) busy_n++;
         if (get_done(w16)) begin
            seen   = 1'b1;
            done_k = k;
         end else if (k == lat - 1) begin
            check({tag, "_c_held"}, get_c(w16), held);
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done expected done within %0d edges", tag, lat + 4);
         void'(exp_q.pop_front());
      end else begin
         check({tag, "_latency"}, 64'(done_k), 64'(lat));
         check({tag, "_c"}, get_c(w16), exp_q.pop_front());
      end
      @(posedge clk); #1;
      check({tag, "_done_clr"}, {63'h0, get_done(w16)}, 64'h0);
      check({tag, "_busy_cnt"}, 64'(busy_n), 64'(lat + 1));
      check({tag, "_busy_clr"}, {63'h0, get_busy(w16)}, 64'h0);
      if (w16) prev_c16 = exp; else prev_c8 = exp;
   endtask

   vec_t vecs[$];

   initial begin
      int unsigned dn;
      int unsigned done_e;
      errors   = 0;
      checks   = 0;
      prev_c8  = '0;
      prev_c16 = '0;

      vecs.push_back('{0, 0, 32'hFF,   32'hFF,   64'hFE01});
      vecs.push_back('{0, 1, 32'h80,   32'h80,   64'h4000});
      vecs.push_back('{0, 1, 32'hFF,   32'h01,   64'hFFFF});
      vecs.push_back('{0, 1, 32'h80,   32'h7F,   64'hC080});
      vecs.push_back('{0, 0, 32'h00,   32'hA5,   64'h0000});
      vecs.push_back('{0, 1, 32'h00,   32'hA5,   64'h0000});
      vecs.push_back('{0, 0, 32'h0D,   32'h0B,   64'h008F});
      vecs.push_back('{0, 1, 32'h7F,   32'h7F,   64'h3F01});
      vecs.push_back('{0, 1, 32'hFE,   32'hFD,   64'h0006});
      vecs.push_back('{1, 0, 32'hFFFF, 32'hFFFF, 64'hFFFE0001});
      vecs.push_back('{1, 1, 32'h8000, 32'h0002, 64'hFFFF0000});
      vecs.push_back('{1, 1, 32'h8000, 32'h8000, 64'h40000000});

      cr = 1'b0;
      drive(0, 1'b0, 1'b0, 0, 0);
      drive(1, 1'b0, 1'b0, 0, 0);
      #12;
      check("rst_c8",    get_c(0), 64'h0);
      check("rst_busy8", {63'h0, if8.busy}, 64'h0);
      check("rst_done8", {63'h0, if8.done}, 64'h0);
      check("rst_c16",   get_c(1), 64'h0);
      @(negedge clk);
      cr = 1'b1;

      foreach (vecs[i])
         run_op(vecs[i].w16, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

      for (int unsigned i = 0; i < 6; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         bit          rs;
         bit          rw;
         ra = $urandom; rb = $urandom; rs = 1'($urandom); rw = (i >= 4);
         run_op(rw, rs, ra, rb, model(rw, rs, ra, rb), $sformatf("rnd%0d", i));
      end

      // start held during CALC with new operands must be ignored entirely.
      drive(0, 1'b1, 1'b0, 3, 5);
      @(posedge clk); #1;
      exp_q.push_back(64'd15);
      dn = 0; done_e = 0;
      for (int unsigned e = 1; e <= 14; e++) begin
         if (e == 1) drive(0, 1'b1, 1'b1, 7, 7);
         if (e == 6) drive(0, 1'b0, 1'b0, 7, 7);
         @(posedge clk); #1;
         if (if8.done) begin
            dn++;
            done_e = e;
            if (exp_q.size() != 0) check("busy_start_c", get_c(0), exp_q.pop_front());
         end
      end
      check("busy_start_ndone", 64'(dn), 64'd1);
      check("busy_start_lat", 64'(done_e), 64'd8);
      prev_c8 = 64'd15;
      run_op(0, 1'b0, 7, 7, 64'd49, "after_busy");

      // Reset part-way through CALC aborts without a done pulse.
      drive(0, 1'b1, 1'b0, 200, 100);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 200, 100);
      repeat (4) @(posedge clk);
      #1;
      cr = 1'b0;
      #1;
      check("abort_c",    get_c(0), 64'h0);
      check("abort_busy", {63'h0, if8.busy}, 64'h0);
      check("abort_done", {63'h0, if8.done}, 64'h0);
      check("abort_c16",  get_c(1), 64'h0);
      prev_c8  = '0;
      prev_c16 = '0;
      dn = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (if8.done) dn++;
      end
      @(negedge clk);
      cr = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (if8.done) dn++;
      end
      check("abort_nodone", 64'(dn), 64'd0);
      check("abort_c_post", get_c(0), 64'h0);
      run_op(0, 1'b0, 12, 12, 64'd144, "post_reset");

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
